xillybus_event_mux: RTL

Parametrised successor to the single-stream event path into the Xillybus core. It merges `NCH` independent event sources into the core's `event_out` data FIFO and `event_size_out` size FIFO, one complete event at a time. Arbitration is round-robin, and each event gets a generated size/header word. Over-length events are truncated and flagged. Events are discarded cleanly when the host has the device files closed.

---
 rtl/xillybus_event_mux.sv | 128 ++++++++++++
 1 files changed

// File: rtl/xillybus_event_mux.sv
// xillybus_event_mux: round-robin merge of NCH event streams into the Xillybus data/size FIFO pair
module xillybus_event_mux #(
  parameter int NCH  = 4,
  parameter int DW   = 64,
  parameter int MAXW = 4096
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic [NCH*DW-1:0] ev_tdata,
  input  logic [NCH-1:0]    ev_tvalid,
  input  logic [NCH-1:0]    ev_tlast,
  output logic [NCH-1:0]    ev_tready,
  output logic [DW-1:0]     user_w_event_out_data,
  output logic              user_w_event_out_wren,
  input  logic              user_w_event_out_full,
  input  logic              user_w_event_out_open,
  output logic [31:0]       user_w_event_size_out_data,
  output logic              user_w_event_size_out_wren,
  input  logic              user_w_event_size_out_full,
  input  logic              user_w_event_size_out_open,
  output logic [15:0]       drop_count
);
  localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, DATA, FLUSH, SIZE} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, rr_q, rr_d, nxt, pick, idx;
  logic [15:0] cnt_q, cnt_d, drop_count_q, drop_count_d, drop_inc;
  logic trunc_q, trunc_d, drop_q, drop_d;
  logic opn, v, l, acc;
  assign opn = user_w_event_out_open & user_w_event_size_out_open;
  assign v = ev_tvalid[gnt_q];
  assign l = ev_tlast[gnt_q];
  assign acc = v & ev_tready[gnt_q];
  assign nxt = (gnt_q == GW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
  assign drop_inc = (&drop_count_q) ? drop_count_q : drop_count_q + 16'd1;
  assign drop_count = drop_count_q;
  assign user_w_event_out_data = ev_tdata[gnt_q*DW +: DW];
  assign user_w_event_out_wren = (state_q == DATA) & v & ~user_w_event_out_full & opn;
  assign user_w_event_size_out_wren = (state_q == SIZE) & ~user_w_event_size_out_full & opn;
  assign user_w_event_size_out_data = (state_q == SIZE) ? {4'(gnt_q), trunc_q, 11'd0, cnt_q} : 32'd0;
  // first valid channel at or after rr, wrapping; lowest offset wins
  always_comb begin
    pick = rr_q;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_q) + k) % NCH);
      if (ev_tvalid[idx]) pick = idx;
    end
  end
  // only the granted channel may see ready; a closed host stops DATA writes at once
  always_comb begin
    ev_tready = '0;
    ev_tready[gnt_q] = (state_q == DATA) ? ~user_w_event_out_full & opn : (state_q == FLUSH);
  end
  // event sequencing: arbitrate, stream, discard tail, emit size word
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    trunc_d = trunc_q;
    drop_d = drop_q;
    drop_count_d = drop_count_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        trunc_d = 1'b0;
        drop_d = ~opn;
        if (|ev_tvalid) begin
          gnt_d = pick;
          state_d = opn ? DATA : FLUSH;
        end
      end
      DATA: begin
        if (!opn) begin
          drop_d = 1'b1;
          state_d = FLUSH;
        end else if (acc) begin
          cnt_d = cnt_q + 16'd1;
          if (l) state_d = SIZE;
          else if (cnt_q == 16'(MAXW - 1)) begin
            trunc_d = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (acc & l) begin
          if (drop_q) begin
            drop_count_d = drop_inc;
            rr_d = nxt;
            state_d = IDLE;
          end else state_d = SIZE;
        end
      end
      default: begin
        if (!opn) begin
          drop_count_d = drop_inc;
          rr_d = nxt;
          state_d = IDLE;
        end else if (!user_w_event_size_out_full) begin
          rr_d = nxt;
          state_d = IDLE;
        end
      end
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      trunc_q <= 1'b0;
      drop_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      trunc_q <= trunc_d;
      drop_q <= drop_d;
      drop_count_q <= drop_count_d;
    end
  end
endmodule
